// File: rtl/clk_ratio_pkg.sv
// Shared types and helpers for clk_ratio_meter: FSM state encoding, default
// counter width and the interval-counter saturation value.
package clk_ratio_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED
    } state_t;

    // All-ones value of a cnt_w-bit counter; the interval counter parks here.
    function automatic int unsigned sat_max(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_ratio_meter_if.sv
// Measurement bundle for clk_ratio_meter: the signal under test going in,
// measured lengths and status coming out. master = meter, slave = consumer.
interface clk_ratio_meter_if #(
    parameter int CNT_W = clk_ratio_pkg::CNT_W_DEF
);
    logic             div_in;
    logic [CNT_W-1:0] hi_len;
    logic [CNT_W-1:0] lo_len;
    logic [CNT_W:0]   period;
    logic             period_valid;
    logic             locked;
    logic             error;

    modport master (
        input  div_in,
        output hi_len, lo_len, period, period_valid, locked, error
    );

    modport slave (
        output div_in,
        input  hi_len, lo_len, period, period_valid, locked, error
    );
endinterface

// File: rtl/clk_edge_det.sv
// Edge detector for the measured signal. Define CLK_RATIO_SYNC_EN to insert a
// two-flop synchronizer ahead of the edge register for asynchronous inputs.
module clk_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic div_in,
    output logic rise,
    output logic fall
);
    logic d_s;
    logic d_q;

`ifdef CLK_RATIO_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= div_in;
            sync2 <= sync1;
        end
    end

    assign d_s = sync2;
`else
    assign d_s = div_in;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge clk) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d_s;
    end

    assign rise = d_s & ~d_q;
    assign fall = ~d_s & d_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures high/low time and period of div_in in clk cycles, locks after
// LOCK_CNT equal periods, pulses error on ratio change or stall.
// Optional input synchronizer: define CLK_RATIO_SYNC_EN (see clk_edge_det).
module clk_ratio_meter
    import clk_ratio_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    clk_ratio_meter_if.master         mif
);
    localparam int               MATCH_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(sat_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_TMO    = CNT_W'(sat_max(CNT_W) - 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);

    logic rise;
    logic fall;
    logic any_edge;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [MATCH_W-1:0] match;
    logic               have_hi;
    logic [CNT_W-1:0]   hi_len_q;
    logic [CNT_W-1:0]   lo_len_q;
    logic [CNT_W:0]     period_q;
    logic               period_valid_q;
    logic               locked_q;
    logic               error_q;

    logic [CNT_W:0]     new_period;
    logic [MATCH_W-1:0] match_next;
    logic               same_period;

    clk_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .div_in (mif.div_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign any_edge = rise | fall;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        new_period  = {1'b0, hi_len_q} + {1'b0, cnt};
        same_period = (match != '0) && (new_period == period_q);
        match_next  = MATCH_W'(1);
        if (same_period) begin
            match_next = (match == MATCH_LOCK) ? match : match + MATCH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            match          <= '0;
            have_hi        <= 1'b0;
            hi_len_q       <= '0;
            lo_len_q       <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            error_q        <= 1'b0;

            if (any_edge)            cnt <= CNT_W'(1);
            else if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    // First edge only opens the window; its partial interval is dropped.
                    if (any_edge) begin
                        state   <= ACQ;
                        have_hi <= 1'b0;
                        match   <= '0;
                    end
                end

                ACQ, LOCKED: begin
                    if (fall) begin
                        hi_len_q <= cnt;
                        have_hi  <= 1'b1;
                    end else if (rise) begin
                        lo_len_q <= cnt;
                        if (have_hi) begin
                            period_q       <= new_period;
                            period_valid_q <= 1'b1;
                            if (state == LOCKED && new_period != period_q) begin
                                error_q  <= 1'b1;
                                locked_q <= 1'b0;
                                state    <= ACQ;
                                match    <= MATCH_W'(1);
                            end else begin
                                match <= match_next;
                                if (match_next == MATCH_LOCK) begin
                                    state    <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end
                        end
                    end else if (cnt == CNT_TMO) begin
                        // Counter saturates this cycle with no edge: treat as a stall.
                        error_q  <= 1'b1;
                        locked_q <= 1'b0;
                        period_q <= '0;
                        hi_len_q <= '0;
                        lo_len_q <= '0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign mif.hi_len       = hi_len_q;
    assign mif.lo_len       = lo_len_q;
    assign mif.period       = period_q;
    assign mif.period_valid = period_valid_q;
    assign mif.locked       = locked_q;
    assign mif.error        = error_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Self-checking bench for clk_ratio_meter: directed ratio scenarios plus random
// waveforms, compared every cycle against an edge-timestamp reference model.
module tb_clk_ratio_meter;

    localparam int CNT_W    = 4;
    localparam int LOCK_CNT = 4;
    localparam int SAT      = (1 << CNT_W) - 1;
`ifdef CLK_RATIO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    clk_ratio_meter_if #(.CNT_W(CNT_W)) mif ();

    clk_ratio_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: edge timestamps and a window of recent periods.
    int  t         = 0;
    int  last_edge = 0;
    bit  prev_ds   = 1'b0;
    bit  idle_m    = 1'b1;
    bit  have_hi_m = 1'b0;
    int  hi_m      = 0;
    int  lo_m      = 0;
    int  per_m     = 0;
    bit  pv_m      = 1'b0;
    bit  err_m     = 1'b0;
    bit  lk_m      = 1'b0;
    int  recent[$];
    bit  pipe[$];

    task automatic clear_meas();
        hi_m  = 0;
        lo_m  = 0;
        per_m = 0;
        lk_m  = 1'b0;
        recent.delete();
    endtask

    task automatic model_step(input bit d, input bit r);
        bit ds;
        bit is_edge;
        bit is_rise;
        bit all_eq;
        int len;
        int p;
        pv_m  = 1'b0;
        err_m = 1'b0;
        if (r) begin
            clear_meas();
            idle_m    = 1'b1;
            have_hi_m = 1'b0;
            prev_ds   = 1'b0;
            pipe.delete();
            for (int i = 0; i < LAT; i++) pipe.push_back(1'b0);
        end else begin
            if (LAT == 0) ds = d;
            else begin
                ds = pipe.pop_front();
                pipe.push_back(d);
            end
            is_edge = (ds != prev_ds);
            is_rise = ds && !prev_ds;
            prev_ds = ds;
            if (is_edge) begin
                if (idle_m) begin
                    idle_m    = 1'b0;
                    have_hi_m = 1'b0;
                    recent.delete();
                end else begin
                    len = t - last_edge;
                    if (!is_rise) begin
                        hi_m      = len;
                        have_hi_m = 1'b1;
                    end else begin
                        lo_m = len;
                        if (have_hi_m) begin
                            p     = hi_m + len;
                            per_m = p;
                            pv_m  = 1'b1;
                            if (lk_m && recent.size() > 0 && p != recent[$]) err_m = 1'b1;
                            recent.push_back(p);
                            if (recent.size() > LOCK_CNT) void'(recent.pop_front());
                            all_eq = (recent.size() == LOCK_CNT);
                            foreach (recent[i]) if (recent[i] != p) all_eq = 1'b0;
                            lk_m = all_eq;
                        end
                    end
                end
                last_edge = t;
            end else if (!idle_m && (t - last_edge) == SAT - 1) begin
                err_m  = 1'b1;
                idle_m = 1'b1;
                clear_meas();
            end
        end
        t++;
    endtask

    task automatic step(input bit d, input bit r);
        mif.div_in = d;
        reset      = r;
        model_step(d, r);
        @(posedge clk);
        @(negedge clk);
        check("hi_len",       mif.hi_len,       hi_m);
        check("lo_len",       mif.lo_len,       lo_m);
        check("period",       mif.period,       per_m);
        check("period_valid", mif.period_valid, pv_m);
        check("locked",       mif.locked,       lk_m);
        check("error",        mif.error,        err_m);
        if (mif.error) err_seen++;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
            for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
        end
    endtask

    task automatic expect_lock(input string tag, input int hi, input int lo);
        check({tag, "_hi"},     mif.hi_len, hi);
        check({tag, "_lo"},     mif.lo_len, lo);
        check({tag, "_period"}, mif.period, hi + lo);
        check({tag, "_locked"}, mif.locked, 1);
    endtask

    initial begin
        int e0;
        int hi;
        int lo;
        int reps;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("reset_period", mif.period, 0);
        check("reset_locked", mif.locked, 0);

        wave(3, 3, 7);
        expect_lock("div6", 3, 3);

        wave(2, 5, 7);
        expect_lock("asym", 2, 5);

        wave(3, 3, 7);
        e0 = err_seen;
        wave(4, 4, 7);
        check("ratio_change_errors", err_seen - e0, 1);
        expect_lock("div8", 4, 4);

        e0 = err_seen;
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0);
        check("stall_errors", err_seen - e0, 1);
        check("stall_period", mif.period, 0);
        check("stall_hi",     mif.hi_len, 0);
        check("stall_locked", mif.locked, 0);

        wave(3, 3, 7);
        expect_lock("relock", 3, 3);
        step(1'b1, 1'b1);
        check("midrst_locked", mif.locked, 0);
        check("midrst_period", mif.period, 0);
        check("midrst_lo",     mif.lo_len, 0);
        wave(3, 3, 7);
        expect_lock("post_rst", 3, 3);

        wave(1, 1, 7);
        expect_lock("min_interval", 1, 1);
        wave(SAT - 1, SAT - 1, 6);
        expect_lock("max_interval", SAT - 1, SAT - 1);

        for (int k = 0; k < 80; k++) begin
            hi   = $urandom_range(1, 9);
            lo   = $urandom_range(1, 9);
            reps = $urandom_range(1, 6);
            if ($urandom_range(0, 9) == 0) hi = $urandom_range(SAT - 3, SAT + 3);
            if ($urandom_range(0, 19) == 0) step(1'($urandom_range(0, 1)), 1'b1);
            wave(hi, lo, reps);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
